// File: rtl/mult_ctrl.sv
// Sequential signed 8x8 shift-add multiplier controller: IDLE -> CALC -> DONE.
// Optional MULT_CTRL_EARLY_EXIT_EN ends CALC as soon as the remaining multiplier bits are zero.
module mult_ctrl #(
  parameter int DW = 8,
  parameter int PW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_multiplicand,
  input  logic [DW-1:0] i_multiplier,
  input  logic          i_ack,
  output logic [PW-1:0] o_product,
  output logic          o_sign,
  output logic          o_stop,
  output logic          o_busy
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_sum;
  logic [DW-1:0] mplier;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [CW-1:0] cnt;
  logic          sign_r;
  logic          capture;
  logic          last_iter;

  // Magnitudes are unsigned DW-bit values, so -2^(DW-1) maps cleanly to 2^(DW-1).
  always_comb begin
    mag_a = i_multiplicand[DW-1] ? (~i_multiplicand + DW'(1)) : i_multiplicand;
    mag_b = i_multiplier[DW-1]   ? (~i_multiplier   + DW'(1)) : i_multiplier;
  end

  assign acc_sum = mplier[0] ? (acc + mcand) : acc;
  assign capture = i_start && ((state == IDLE) || (state == DONE));

`ifdef MULT_CTRL_EARLY_EXIT_EN
  assign last_iter = (cnt == CW'(DW-1)) || (mplier[DW-1:1] == '0);
`else
  assign last_iter = (cnt == CW'(DW-1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE: begin
        if (i_start)    state_nxt = CALC;
        else if (i_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      o_product <= '0;
      o_sign    <= 1'b0;
    end else if (capture) begin
      mcand     <= {{(PW-DW){1'b0}}, mag_a};
      mplier    <= mag_b;
      sign_r    <= i_multiplicand[DW-1] ^ i_multiplier[DW-1];
      acc       <= '0;
      cnt       <= '0;
      o_product <= '0;
    end else if (state == CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_iter) begin
        o_product <= acc_sum;
        // A zero product is never reported as negative.
        o_sign    <= sign_r & (|acc_sum);
      end
    end
  end

  assign o_stop = (state == DONE);
  assign o_busy = (state == CALC);

endmodule

// File: tb/tb_mult_ctrl.sv
// Randomized self-checking bench for mult_ctrl against an integer-arithmetic reference.
// Honors MULT_CTRL_EARLY_EXIT_EN for the expected latency.
module tb_mult_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_multiplicand;
  logic [7:0]  i_multiplier;
  logic        i_ack;
  logic [15:0] o_product;
  logic        o_sign;
  logic        o_stop;
  logic        o_busy;

  int vectors;
  int miscompares;
  bit clk_run;

  mult_ctrl #(.DW(8), .PW(16)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_ack          (i_ack),
    .o_product      (o_product),
    .o_sign         (o_sign),
    .o_stop         (o_stop),
    .o_busy         (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    wait (clk_run);
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Cycles spent in CALC for a given multiplier.
  function automatic int exp_latency(input int b);
`ifdef MULT_CTRL_EARLY_EXIT_EN
    int m;
    int h;
    m = iabs(b);
    if (m == 0) return 1;
    h = 0;
    for (int i = 0; i < 8; i++) if (((m >> i) & 1) != 0) h = i;
    return h + 1;
`else
    return 8;
`endif
  endfunction

  // Start an operation (optionally with i_ack high too) and check the result.
  task automatic run_op(input int a, input int b, input bit with_ack, input bit inject);
    int  exp_p;
    int  exp_l;
    int  busy_n;
    int  cyc;
    bit  zero_ok;
    exp_p = a * b;
    exp_l = exp_latency(b);
    @(negedge i_clk);
    i_multiplicand = 8'(a);
    i_multiplier   = 8'(b);
    i_start        = 1'b1;
    i_ack          = with_ack;
    @(posedge i_clk);
    #1;
    i_start        = 1'b0;
    i_ack          = 1'b0;
    i_multiplicand = 8'($urandom);
    i_multiplier   = 8'($urandom);
    busy_n  = 0;
    cyc     = 0;
    zero_ok = 1'b1;
    while (cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (o_stop) break;
      if (o_busy) busy_n++;
      if (o_busy && o_product != 16'd0) zero_ok = 1'b0;
      if (inject && exp_l > 3 && cyc == 3) begin
        i_start        = 1'b1;
        i_ack          = 1'b1;
        i_multiplicand = 8'($urandom);
        i_multiplier   = 8'($urandom);
      end else begin
        i_start = 1'b0;
        i_ack   = 1'b0;
      end
    end
    i_start = 1'b0;
    i_ack   = 1'b0;
    check($sformatf("stop_seen a=%0d b=%0d", a, b), int'(o_stop), 1);
    check($sformatf("latency a=%0d b=%0d", a, b), busy_n, exp_l);
    check($sformatf("product a=%0d b=%0d", a, b), int'(o_product), iabs(exp_p));
    check($sformatf("sign a=%0d b=%0d", a, b), int'(o_sign), (exp_p < 0) ? 1 : 0);
    check("busy_in_done", int'(o_busy), 0);
    check("product_zero_in_calc", int'(zero_ok), 1);
  endtask

  task automatic do_ack();
    int held_p;
    int held_s;
    held_p = int'(o_product);
    held_s = int'(o_sign);
    @(negedge i_clk);
    i_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_ack = 1'b0;
    check("stop_after_ack", int'(o_stop), 0);
    check("busy_after_ack", int'(o_busy), 0);
    check("product_held_idle", int'(o_product), held_p);
    check("sign_held_idle", int'(o_sign), held_s);
    repeat (2) @(negedge i_clk);
    check("stays_idle", int'(o_stop | o_busy), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_product"}, int'(o_product), 0);
    check({tag, "_sign"}, int'(o_sign), 0);
    check({tag, "_stop"}, int'(o_stop), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
  endtask

  initial begin
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    int mode;
    vectors        = 0;
    miscompares    = 0;
    clk_run        = 1'b0;
    i_rst          = 1'b1;
    i_start        = 1'b0;
    i_ack          = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;

    // Reset with no clock running.
    #3;
    check_cleared("reset_noclk");
    clk_run = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("idle_after_reset", int'(o_stop | o_busy), 0);

    run_op(5, -3, 1'b0, 1'b0);
    do_ack();
    run_op(-128, -128, 1'b0, 1'b0);
    run_op(127, -128, 1'b0, 1'b0);
    run_op(0, -7, 1'b0, 1'b0);
    run_op(9, 3, 1'b0, 1'b0);
    run_op(-7, 0, 1'b0, 1'b0);
    do_ack();
    run_op(13, -11, 1'b0, 1'b1);
    run_op(-100, 50, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) do_ack();
      run_op(int'(ra), int'(rb), mode == 2, n % 5 == 0);
    end

    // Reset while holding a nonzero result in DONE.
    run_op(-77, 91, 1'b0, 1'b0);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_cleared("reset_in_done");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset at CALC iteration 4.
    @(negedge i_clk);
    i_multiplicand = 8'(-45);
    i_multiplier   = 8'(99);
    i_start        = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    check("busy_before_reset", int'(o_busy), 1);
    i_rst = 1'b1;
    #1;
    check_cleared("reset_mid_calc");
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op(2, 3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
